// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// register offsets, FSM state types and the byte-strobe merge helper.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   localparam logic [7:0] ADDR_CTRL    = 8'h00;
   localparam logic [7:0] ADDR_DATA_IN = 8'h04;
   localparam logic [7:0] ADDR_STATUS  = 8'h08;
   localparam logic [7:0] ADDR_RESULT  = 8'h0C;

   // Widest bus the merge helper handles; narrower buses are zero-extended.
   localparam int unsigned MAX_DATA_WIDTH = 64;
   localparam int unsigned MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      W_IDLE      = 2'd0,
      W_HAVE_ADDR = 2'd1,
      W_HAVE_DATA = 2'd2,
      W_RESP      = 2'd3
   } wstate_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_e;

   function automatic logic [MAX_DATA_WIDTH-1:0] merge_strb(
      input logic [MAX_DATA_WIDTH-1:0] old_v,
      input logic [MAX_DATA_WIDTH-1:0] new_v,
      input logic [MAX_STRB_WIDTH-1:0] strb
   );
      logic [MAX_DATA_WIDTH-1:0] res;
      res = old_v;
      for (int i = 0; i < int'(MAX_STRB_WIDTH); i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_v[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_v[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_lite_regslave.sv
// AXI4-Lite slave with CTRL/DATA_IN/STATUS/RESULT accumulator registers.
// Define AXI_REGSLAVE_ERR_RESP_EN to return SLVERR for undecoded or read-only accesses.
module axi_lite_regslave
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_WIDTH = 3
) (
   input  logic                      s_axi_aclk,
   input  logic                      s_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [RESP_WIDTH-1:0]     s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [RESP_WIDTH-1:0]     s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(ADDR_CTRL);
   localparam logic [ADDR_WIDTH-1:0] A_DATA_IN = ADDR_WIDTH'(ADDR_DATA_IN);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(ADDR_STATUS);
   localparam logic [ADDR_WIDTH-1:0] A_RESULT  = ADDR_WIDTH'(ADDR_RESULT);

   wstate_e                 wstate_q;
   logic                    awready_q, wready_q, bvalid_q;
   logic [RESP_WIDTH-1:0]   bresp_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]   wstrb_q;

   rstate_e                 rstate_q;
   logic                    arready_q, rvalid_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [RESP_WIDTH-1:0]   rresp_q;

   logic                    acc_en_q, acc_en_d;
   logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic                    overflow_q, overflow_d;
   logic [15:0]             wcount_q, wcount_d;

   logic                    aw_hs, w_hs;
   logic                    wr_fire;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [STRB_WIDTH-1:0]   wr_strb;
   logic                    wr_is_ctrl, wr_is_data;
   logic [RESP_WIDTH-1:0]   wr_resp;
   logic [DATA_WIDTH-1:0]   ctrl_merged, data_merged;
   logic [DATA_WIDTH:0]     acc_sum;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic [RESP_WIDTH-1:0]   rd_resp;

   assign aw_hs = s_axi_awvalid & awready_q;
   assign w_hs  = s_axi_wvalid & wready_q;

   // Select the address/data halves of the write that completes this cycle.
   always_comb begin
      wr_fire = 1'b0;
      wr_addr = awaddr_q;
      wr_data = wdata_q;
      wr_strb = wstrb_q;
      case (wstate_q)
         W_IDLE: begin
            wr_addr = s_axi_awaddr;
            wr_data = s_axi_wdata;
            wr_strb = s_axi_wstrb;
            wr_fire = aw_hs & w_hs;
         end
         W_HAVE_ADDR: begin
            wr_data = s_axi_wdata;
            wr_strb = s_axi_wstrb;
            wr_fire = w_hs;
         end
         W_HAVE_DATA: begin
            wr_addr = s_axi_awaddr;
            wr_fire = aw_hs;
         end
         default: begin
            wr_fire = 1'b0;
         end
      endcase
   end

   assign wr_is_ctrl  = (wr_addr == A_CTRL);
   assign wr_is_data  = (wr_addr == A_DATA_IN);
   assign ctrl_merged = DATA_WIDTH'(merge_strb(MAX_DATA_WIDTH'(acc_en_q), MAX_DATA_WIDTH'(wr_data),
                                               MAX_STRB_WIDTH'(wr_strb)));
   assign data_merged = DATA_WIDTH'(merge_strb(MAX_DATA_WIDTH'(data_in_q), MAX_DATA_WIDTH'(wr_data),
                                               MAX_STRB_WIDTH'(wr_strb)));
   assign acc_sum     = {1'b0, result_q} + {1'b0, data_merged};

`ifdef AXI_REGSLAVE_ERR_RESP_EN
   assign wr_resp = (wr_is_ctrl | wr_is_data) ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
`else
   assign wr_resp = RESP_WIDTH'(RESP_OKAY);
`endif

   // Register file next state; CLR wins over accumulation.
   always_comb begin
      acc_en_d   = acc_en_q;
      data_in_d  = data_in_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      wcount_d   = wcount_q;
      if (wr_fire && wr_is_ctrl) begin
         acc_en_d = ctrl_merged[0];
         wcount_d = wcount_q + 16'd1;
         if (ctrl_merged[1]) begin
            result_d   = '0;
            overflow_d = 1'b0;
         end else begin
            result_d   = result_q;
         end
      end else if (wr_fire && wr_is_data) begin
         data_in_d = data_merged;
         wcount_d  = wcount_q + 16'd1;
         if (acc_en_q) begin
            result_d   = acc_sum[DATA_WIDTH-1:0];
            overflow_d = overflow_q | acc_sum[DATA_WIDTH];
         end else begin
            result_d   = result_q;
         end
      end else begin
         wcount_d = wcount_q;
      end
   end

   // Register file state.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         acc_en_q   <= 1'b0;
         data_in_q  <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         wcount_q   <= 16'd0;
      end else begin
         acc_en_q   <= acc_en_d;
         data_in_q  <= data_in_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         wcount_q   <= wcount_d;
      end
   end

   // Write channel FSM with registered ready/valid/response outputs.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (aw_hs && w_hs) begin
                  wstate_q  <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_resp;
               end else if (aw_hs) begin
                  wstate_q  <= W_HAVE_ADDR;
                  awaddr_q  <= s_axi_awaddr;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
               end else if (w_hs) begin
                  wstate_q  <= W_HAVE_DATA;
                  wdata_q   <= s_axi_wdata;
                  wstrb_q   <= s_axi_wstrb;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b0;
               end else begin
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_HAVE_ADDR: begin
               if (w_hs) begin
                  wstate_q <= W_RESP;
                  wready_q <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= wr_resp;
               end
            end
            W_HAVE_DATA: begin
               if (aw_hs) begin
                  wstate_q  <= W_RESP;
                  awready_q <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_resp;
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  wstate_q  <= W_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: begin
               wstate_q  <= W_IDLE;
               awready_q <= 1'b0;
               wready_q  <= 1'b0;
               bvalid_q  <= 1'b0;
            end
         endcase
      end
   end

   // Read decode uses current register values, so a same-edge write is not visible.
   always_comb begin
      rd_data = '0;
      rd_resp = RESP_WIDTH'(RESP_OKAY);
      if (s_axi_araddr == A_CTRL) begin
         rd_data = DATA_WIDTH'(acc_en_q);
      end else if (s_axi_araddr == A_DATA_IN) begin
         rd_data = data_in_q;
      end else if (s_axi_araddr == A_STATUS) begin
         rd_data = DATA_WIDTH'({overflow_q, wcount_q});
      end else if (s_axi_araddr == A_RESULT) begin
         rd_data = result_q;
      end else begin
         rd_data = '0;
`ifdef AXI_REGSLAVE_ERR_RESP_EN
         rd_resp = RESP_WIDTH'(RESP_SLVERR);
`else
         rd_resp = RESP_WIDTH'(RESP_OKAY);
`endif
      end
   end

   // Read channel FSM; rdata/rresp are latched at the AR handshake and held.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (s_axi_arvalid && arready_q) begin
                  rstate_q  <= R_DATA;
                  rdata_q   <= rd_data;
                  rresp_q   <= rd_resp;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  rstate_q  <= R_IDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: begin
               rstate_q  <= R_IDLE;
               rvalid_q  <= 1'b0;
               arready_q <= 1'b0;
            end
         endcase
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regslave.sv
// Directed self-checking bench for axi_lite_regslave.
module tb_axi_lite_regslave;

   localparam logic [7:0] A_CTRL   = 8'h00;
   localparam logic [7:0] A_DATA   = 8'h04;
   localparam logic [7:0] A_STATUS = 8'h08;
   localparam logic [7:0] A_RESULT = 8'h0C;
`ifdef AXI_REGSLAVE_ERR_RESP_EN
   localparam logic [2:0] EXP_ERR = 3'd2;
`else
   localparam logic [2:0] EXP_ERR = 3'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
   logic [2:0]  s_axi_bresp, s_axi_rresp;
   logic [31:0] s_axi_rdata;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rdv;
   logic [2:0]  rrv;

   always #5 clk = ~clk;

   axi_lite_regslave dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .s_axi_awaddr  (awaddr),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (rready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: observed timeout expected handshake", tag);
   endtask

   task automatic wr_hs(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!(s_axi_awready && s_axi_wready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout("wr_hs");
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] exp_resp);
      wr_hs(a, d, s);
      check({tag, ".bvalid"}, 32'(s_axi_bvalid), 32'd1);
      check({tag, ".bresp"}, 32'(s_axi_bresp), 32'(exp_resp));
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout("rd_hs");
      @(posedge clk); #1;
      arvalid = 1'b0;
      check("rd.rvalid", 32'(s_axi_rvalid), 32'd1);
      d = s_axi_rdata;
      r = s_axi_rresp;
      if (rready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                         input logic [2:0] exp_r);
      logic [31:0] d;
      logic [2:0]  r;
      rd(a, d, r);
      check({tag, ".rdata"}, d, exp_d);
      check({tag, ".rresp"}, 32'(r), 32'(exp_r));
   endtask

   initial begin
      int n;
      int cyc;
      rst_n = 1'b0; awaddr = 8'h00; araddr = 8'h00; awvalid = 1'b0; wvalid = 1'b0;
      arvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; bready = 1'b1; rready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst.awready", 32'(s_axi_awready), 32'd0);
      check("rst.wready", 32'(s_axi_wready), 32'd0);
      check("rst.arready", 32'(s_axi_arready), 32'd0);
      check("rst.bvalid", 32'(s_axi_bvalid), 32'd0);
      check("rst.rvalid", 32'(s_axi_rvalid), 32'd0);
      check("rst.bresp", 32'(s_axi_bresp), 32'd0);
      check("rst.rresp", 32'(s_axi_rresp), 32'd0);
      check("rst.rdata", s_axi_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst.awready", 32'(s_axi_awready), 32'd1);
      check("post_rst.wready", 32'(s_axi_wready), 32'd1);
      check("post_rst.arready", 32'(s_axi_arready), 32'd1);

      // AW and W together
      wr("w_data5", A_DATA, 32'h0000_0005, 4'hF, 3'd0);
      rd_chk("r_data5", A_DATA, 32'h0000_0005, 3'd0);

      // W first, AW three cycles later
      @(negedge clk);
      awaddr = A_CTRL; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      check("wfirst.wready", 32'(s_axi_wready), 32'd0);
      check("wfirst.awready", 32'(s_axi_awready), 32'd1);
      check("wfirst.bvalid", 32'(s_axi_bvalid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      check("wfirst.bvalid_c4", 32'(s_axi_bvalid), 32'd1);
      check("wfirst.bresp", 32'(s_axi_bresp), 32'd0);
      @(posedge clk); #1;
      rd_chk("r_ctrl_acc", A_CTRL, 32'h1, 3'd0);
      wr("w_strb1", A_DATA, 32'hFFFF_FF10, 4'h1, 3'd0);
      rd_chk("r_result10", A_RESULT, 32'h10, 3'd0);
      rd_chk("r_data10", A_DATA, 32'h10, 3'd0);
      rd_chk("r_status3", A_STATUS, 32'h3, 3'd0);

      // Overflow and clear
      wr("w_ctrl3a", A_CTRL, 32'h3, 4'hF, 3'd0);
      rd_chk("r_ctrl_clr_reads0", A_CTRL, 32'h1, 3'd0);
      rd_chk("r_result_clr", A_RESULT, 32'h0, 3'd0);
      wr("w_ffff", A_DATA, 32'hFFFF_FFFF, 4'hF, 3'd0);
      rd_chk("r_result_ffff", A_RESULT, 32'hFFFF_FFFF, 3'd0);
      rd_chk("r_status5", A_STATUS, 32'h5, 3'd0);
      wr("w_two", A_DATA, 32'h2, 4'hF, 3'd0);
      rd_chk("r_result_wrap", A_RESULT, 32'h1, 3'd0);
      rd_chk("r_status_ovf", A_STATUS, 32'h0001_0006, 3'd0);
      wr("w_ctrl3b", A_CTRL, 32'h3, 4'hF, 3'd0);
      rd_chk("r_result_clr2", A_RESULT, 32'h0, 3'd0);
      rd_chk("r_status_ovf_clr", A_STATUS, 32'h7, 3'd0);

      // Read-only write, partial strobe with ACC_EN off
      wr("w_ro", A_RESULT, 32'h1234, 4'hF, EXP_ERR);
      rd_chk("r_result_ro", A_RESULT, 32'h0, 3'd0);
      rd_chk("r_status_ro", A_STATUS, 32'h7, 3'd0);
      wr("w_ctrl0", A_CTRL, 32'h0, 4'hF, 3'd0);
      wr("w_strb6", A_DATA, 32'hAABB_CCDD, 4'h6, 3'd0);
      rd_chk("r_data_strb6", A_DATA, 32'h00BB_CC02, 3'd0);
      rd_chk("r_result_noacc", A_RESULT, 32'h0, 3'd0);

      // Backpressure on B and R, read served while write response is stalled
      bready = 1'b0;
      wr_hs(A_DATA, 32'h1122_3344, 4'hF);
      check("bp.bvalid0", 32'(s_axi_bvalid), 32'd1);
      rready = 1'b0;
      rd(A_DATA, rdv, rrv);
      check("bp.rdata0", rdv, 32'h1122_3344);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp.bvalid", 32'(s_axi_bvalid), 32'd1);
         check("bp.bresp", 32'(s_axi_bresp), 32'd0);
         check("bp.awready", 32'(s_axi_awready), 32'd0);
         check("bp.rvalid", 32'(s_axi_rvalid), 32'd1);
         check("bp.rdata", s_axi_rdata, 32'h1122_3344);
         check("bp.arready", 32'(s_axi_arready), 32'd0);
      end
      @(negedge clk);
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      check("bp.bvalid_done", 32'(s_axi_bvalid), 32'd0);
      check("bp.rvalid_done", 32'(s_axi_rvalid), 32'd0);
      check("bp.awready_back", 32'(s_axi_awready), 32'd1);
      check("bp.arready_back", 32'(s_axi_arready), 32'd1);

      // Read and write of DATA_IN on the same edge
      @(negedge clk);
      awaddr = A_DATA; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = A_DATA; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("same.rvalid", 32'(s_axi_rvalid), 32'd1);
      check("same.rdata_old", s_axi_rdata, 32'h1122_3344);
      check("same.bvalid", 32'(s_axi_bvalid), 32'd1);
      @(posedge clk); #1;
      rd_chk("r_data55", A_DATA, 32'h55, 3'd0);

      // Undecoded accesses
      rd_chk("r_undec", 8'h20, 32'h0, EXP_ERR);
      wr("w_undec", 8'h40, 32'hDEAD_BEEF, 4'hF, EXP_ERR);
      rd_chk("r_status11", A_STATUS, 32'hB, 3'd0);

      // Reset in the middle of a write
      @(negedge clk);
      awaddr = A_DATA; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      check("mid.wready", 32'(s_axi_wready), 32'd1);
      check("mid.awready", 32'(s_axi_awready), 32'd0);
      @(negedge clk);
      rst_n = 1'b0; wdata = 32'hFFFF_FFFF; wvalid = 1'b1;
      #1;
      check("mid.rst_wready", 32'(s_axi_wready), 32'd0);
      @(negedge clk);
      wvalid = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      rd_chk("r_mid_data", A_DATA, 32'h0, 3'd0);
      rd_chk("r_mid_status", A_STATUS, 32'h0, 3'd0);

      // Write counter wrap: stream back-to-back writes
      @(negedge clk);
      awaddr = A_DATA; wdata = 32'hA5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      n = 0; cyc = 0;
      while (n < 65535 && cyc < 3 * 65535) begin
         @(posedge clk); #1;
         cyc++;
         if (s_axi_bvalid) n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (n != 65535) timeout("wrap_stream");
      @(posedge clk); #1;
      rd_chk("r_status_ffff", A_STATUS, 32'h0000_FFFF, 3'd0);
      wr("w_last", A_DATA, 32'h5A, 4'hF, 3'd0);
      rd_chk("r_status_wrap", A_STATUS, 32'h0, 3'd0);
      rd_chk("r_data_last", A_DATA, 32'h5A, 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
